// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the vector accelerator.
package acc_pkg;
   localparam int ACC_NUM_WORDS = 256;
   typedef logic [3:0][7:0] acc_word_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DOT} acc_op_e;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} acc_state_e;
endpackage

// File: rtl/acc_vec_engine_if.sv
// acc_vec_engine_if: software start/busy/done control handshake.
interface acc_vec_engine_if #(parameter int LEN_WIDTH = 9) ();
   logic                 start;
   logic [1:0]           op;
   logic [LEN_WIDTH-1:0] len;
   logic                 busy;
   logic                 done;
   modport master (output start, op, len, input busy, done);
   modport slave  (input start, op, len, output busy, done);
endinterface

// File: rtl/acc_lane_alu.sv
// acc_lane_alu: combinational per-word lane ALU (add/sub/mul per lane, 4-lane dot product).
module acc_lane_alu
   import acc_pkg::*;
(
   input  acc_op_e   i_op,
   input  acc_word_t i_a,
   input  acc_word_t i_b,
   output acc_word_t o_res
);
   logic [3:0][15:0] w_prod;
   logic [17:0]      w_dot;
   always_comb begin
      w_dot = '0;
      o_res = '0;
      for (int k = 0; k < 4; k++) begin
         w_prod[k] = 16'(i_a[k]) * 16'(i_b[k]);
         w_dot     = w_dot + 18'(w_prod[k]);
         o_res[k]  = i_op == OP_ADD ? i_a[k] + i_b[k] :
                     i_op == OP_SUB ? i_a[k] - i_b[k] : w_prod[k][7:0];
      end
      if (i_op == OP_DOT) o_res = 32'(w_dot);
   end
endmodule

// File: rtl/acc_vec_engine.sv
// acc_vec_engine: one-word-per-cycle vector engine with a two-stage pipeline
// (operand read + ALU into stage 1, result bank write from stage 1).
module acc_vec_engine
   import acc_pkg::*;
#(
   parameter int NUM_WORDS = ACC_NUM_WORDS,
   parameter int LEN_WIDTH = 9
) (
   input  logic                           clk,
   input  logic                           rst_n,
   acc_vec_engine_if.slave                bus,
   input  acc_word_t [NUM_WORDS-1:0]      i_acc_a,
   input  acc_word_t [NUM_WORDS-1:0]      i_acc_b,
   output acc_word_t [NUM_WORDS-1:0]      o_acc_res
);
   localparam int IDX_W = $clog2(NUM_WORDS);
   acc_state_e               r_state, w_next;
   acc_op_e                  r_op;
   logic [LEN_WIDTH-1:0]     r_len, w_len;
   logic [IDX_W-1:0]         r_idx, r_idx1;
   logic                     r_v1, r_busy, r_done, w_last;
   acc_word_t                r_res1, w_res;
   acc_word_t [NUM_WORDS-1:0] r_res;
   acc_lane_alu u_alu (
      .i_op  (r_op),
      .i_a   (i_acc_a[r_idx]),
      .i_b   (i_acc_b[r_idx]),
      .o_res (w_res)
   );
   assign w_len     = bus.len > LEN_WIDTH'(NUM_WORDS) ? LEN_WIDTH'(NUM_WORDS) : bus.len;
   assign w_last    = LEN_WIDTH'(r_idx) == r_len - LEN_WIDTH'(1);
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;
   assign o_acc_res = r_res;
   // A zero-length run passes through DRAIN (stage 1 empty) so done lands one cycle after start.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = bus.start ? (w_len == '0 ? S_DRAIN : S_RUN) : S_IDLE;
         S_RUN:   w_next = w_last ? S_DRAIN : S_RUN;
         S_DRAIN: w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= OP_ADD;
         r_len   <= '0;
         r_idx   <= '0;
         r_idx1  <= '0;
         r_v1    <= 1'b0;
         r_res1  <= '0;
         r_res   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= r_state == S_RUN;
         r_done  <= w_next == S_DONE;
         r_v1    <= r_state == S_RUN;
         r_idx1  <= r_idx;
         r_res1  <= w_res;
         if (r_state == S_IDLE && bus.start) begin
            r_op  <= acc_op_e'(bus.op);
            r_len <= w_len;
            r_idx <= '0;
         end else if (r_state == S_RUN) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         if (r_v1) r_res[r_idx1] <= r_res1;
      end
   end
endmodule

// File: tb/tb_acc_vec_engine.sv
// tb_acc_vec_engine: random and directed runs checked against a lane-arithmetic model
// through a done-triggered scoreboard.
module tb_acc_vec_engine;
   import acc_pkg::*;
   typedef acc_word_t [255:0] pbank_t;
   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   pbank_t a_bank, b_bank, res_bank, exp_bank, mon_e;
   pbank_t exp_q[$];
   int     checks = 0, errors = 0, mon_bad;
   acc_vec_engine_if #(.LEN_WIDTH(9)) bus ();
   acc_vec_engine #(.NUM_WORDS(256), .LEN_WIDTH(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .i_acc_a   (a_bank),
      .i_acc_b   (b_bank),
      .o_acc_res (res_bank)
   );
   always #5 clk = ~clk;
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not end, checks %0d", checks);
      $fatal(1, "watchdog");
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic acc_word_t model(input logic [1:0] op, input acc_word_t a, input acc_word_t b);
      acc_word_t r;
      int s, x, y;
      s = 0;
      for (int k = 0; k < 4; k++) begin
         x = int'(a[k]);
         y = int'(b[k]);
         s += x * y;
         r[k] = op == 2'd0 ? 8'((x + y) % 256) :
                op == 2'd1 ? 8'((x - y + 256) % 256) : 8'((x * y) % 256);
      end
      return op == 2'd3 ? 32'(s) : r;
   endfunction
   // Scoreboard: every done pulse must match the oldest outstanding expected bank.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got done=1 expected no pending run");
         end else begin
            mon_e = exp_q.pop_front();
            mon_bad = -1;
            for (int i = 0; i < 256; i++)
               if (res_bank[i] !== mon_e[i] && mon_bad < 0) mon_bad = i;
            if (mon_bad >= 0) begin
               errors++;
               $display("FAIL bank_word_%0d: got %h expected %h", mon_bad, res_bank[mon_bad], mon_e[mon_bad]);
            end
         end
      end
   end
   task automatic run(input logic [1:0] op, input int len, input bit hold);
      int     l;
      pbank_t old;
      l = len > 256 ? 256 : len;
      old = exp_bank;
      for (int i = 0; i < l; i++) exp_bank[i] = model(op, a_bank[i], b_bank[i]);
      exp_q.push_back(exp_bank);
      bus.op = op;
      bus.len = 9'(len);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      for (int k = 1; k <= l + 2; k++) begin
         @(posedge clk);
         #1;
         if (hold) bus.len = 9'($urandom_range(0, 511));
         chk($sformatf("busy_k%0d_len%0d", k, len), 32'(bus.busy), 32'(k <= l));
         chk($sformatf("done_k%0d_len%0d", k, len), 32'(bus.done), 32'(k == l + 1));
         if (k == 2 && l >= 1) chk("first_write_word0", res_bank[0], exp_bank[0]);
         if (k == 2 && l >= 2) chk("word1_not_yet_written", res_bank[1], old[1]);
      end
   endtask
   task automatic fill_random();
      for (int i = 0; i < 256; i++) begin
         a_bank[i] = $urandom();
         b_bank[i] = $urandom();
      end
   endtask
   initial begin
      bus.start = 1'b0;
      bus.op = 2'd0;
      bus.len = '0;
      a_bank = '0;
      b_bank = '0;
      exp_bank = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_bank_nonzero", 32'(res_bank != '0), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      a_bank = '1;
      b_bank = '1;
      run(2'd3, 256, 1'b0);
      chk("dot_max_word255", res_bank[255], 32'h0003_F804);
      a_bank[3:0] = {4{32'hFF01_8080}};
      b_bank[3:0] = {4{32'h0101_8080}};
      run(2'd0, 4, 1'b0);
      chk("add_wrap_word3", res_bank[3], 32'h0002_0000);
      chk("add_word4_kept", res_bank[4], 32'h0003_F804);
      a_bank[0] = 32'h0010_2003;
      b_bank[0] = 32'h0120_1005;
      run(2'd1, 1, 1'b0);
      chk("sub_word0", res_bank[0], 32'hFFF0_10FE);
      run(2'd2, 1, 1'b0);
      chk("mul_word0", res_bank[0], 32'h0000_000F);
      fill_random();
      run(2'd0, 0, 1'b0);
      chk("len0_no_write", res_bank[0], 32'h0000_000F);
      run(2'(($urandom() % 4)), 300, 1'b0);
      fill_random();
      run(2'd0, 8, 1'b1);
      run(2'd2, 5, 1'b0);
      for (int r = 0; r < 10; r++) begin
         fill_random();
         run(2'($urandom_range(0, 3)), $urandom_range(0, 300), 1'b0);
      end
      fill_random();
      bus.op = 2'd0;
      bus.len = 9'd256;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrun_reset_bank", 32'(res_bank != '0), 32'd0);
      chk("midrun_reset_busy", 32'(bus.busy), 32'd0);
      exp_bank = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_done", 32'(bus.done), 32'd0);
      chk("post_reset_bank", 32'(res_bank != '0), 32'd0);
      run(2'd1, 6, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
